// File: rtl/ysyx_220066_if_fetch.sv
// rtl/ysyx_220066_if_fetch.sv - instruction fetch stage: PC, request credit, decode FIFO
//
// Owns the fetch PC and issues in-order word requests to instruction memory.
// Returned words are buffered with their PCs and handed to decode over a
// valid/ready handshake. A redirect squashes buffered and in-flight fetches.
//
// Optional feature macro: YSYX_220066_IF_BYPASS_EN
//   Defined  : a response arriving while the FIFO is empty is presented to
//              decode in the same cycle and skips the FIFO if accepted.
//   Undefined: every response is registered into the FIFO first.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   imem_req/addr/gnt        request channel toward instruction memory
//   imem_rvalid/rdata        in-order response channel
//   redirect, redirect_pc    single-cycle restart pulse from execute
//   id_ready                 decode can accept the head instruction
//   valid, instr, pc         head instruction toward decode
//   misalign                 last redirect target was not word aligned
module ysyx_220066_if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        valid,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        misalign
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic          misalign_q, misalign_d;

  // Request-PC side FIFO and the {pc, instr} decode FIFO.
  logic [63:0] pcq_mem    [DEPTH];
  logic [63:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];

  logic gnt_fire, rsp_live, head_valid, bypass_hit, bypass_take, push, pop;

  // Counters are registered, so a bypass-consumed response frees its credit
  // through the inflight decrement on the following cycle.
  assign imem_req  = !misalign_q && !redirect &&
                     (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  // A response is live (kept) only when no stale responses remain to drop
  // and no redirect is squashing this cycle.
  assign rsp_live   = imem_rvalid && (drop_q == '0) && !redirect;
  assign head_valid = (count_q != '0);

`ifdef YSYX_220066_IF_BYPASS_EN
  assign bypass_hit = rsp_live && !head_valid;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit && id_ready;

  assign push = rsp_live && !bypass_take;
  assign pop  = head_valid && !redirect && id_ready;

  assign valid    = (head_valid || bypass_hit) && !redirect;
  assign instr    = head_valid ? fifo_instr[rd_ptr_q] : (bypass_hit ? imem_rdata : 32'd0);
  assign pc       = head_valid ? fifo_pc[rd_ptr_q] : (bypass_hit ? pcq_mem[pcq_rd_q] : 64'd0);
  assign misalign = misalign_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(gnt_fire) - CW'(imem_rvalid);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    misalign_d = misalign_q;
    if (redirect) begin
      // Everything still outstanding after this cycle is stale.
      fetch_pc_d = redirect_pc;
      misalign_d = (redirect_pc[1:0] != 2'b00);
      drop_d     = inflight_q - CW'(imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
        pcq_wr_d   = pcq_wr_q + PW'(1);
      end
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (rsp_live) pcq_rd_d = pcq_rd_q + PW'(1);
      if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage arrays carry no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (gnt_fire) pcq_mem[pcq_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_pc[wr_ptr_q]    <= pcq_mem[pcq_rd_q];
      fifo_instr[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_if_fetch.sv
// tb/tb_ysyx_220066_if_fetch.sv - scoreboard bench for ysyx_220066_if_fetch
module tb_ysyx_220066_if_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        misalign;

  ysyx_220066_if_fetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .valid(valid), .instr(instr), .pc(pc), .misalign(misalign)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lat   = 1;

  // memory model: granted addresses with the cycle their response is due
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  // scoreboard of PCs decode must receive, in order
  logic [63:0] sb_pc[$];

  // values sampled in the most recent cycle
  logic        s_req, s_valid, s_mis, x_fire;
  logic [63:0] s_addr, s_pc, x_pc;
  logic [31:0] s_instr, x_instr;

  task automatic cycle();
    if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0][31:0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = valid;
    s_pc    = pc;
    s_instr = instr;
    s_mis   = misalign;
    x_fire  = valid && id_ready;
    x_pc    = pc;
    x_instr = instr;
    @(posedge clk);
    if (s_req && imem_gnt) begin
      mq_addr.push_back(s_addr);
      mq_due.push_back(cyc + lat);
    end
    if (imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 64'h0;
    id_ready = 1'b0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    mq_addr.delete();
    mq_due.delete();
    sb_pc.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL reset_instr got %h want 0", instr); end
    tests++; if (pc !== 64'h0) begin fails++; $display("FAIL reset_pc got %h want 0", pc); end
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b want 0", misalign); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_req got %b want 1", imem_req); end
    tests++; if (imem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_straight_line();
    int first_cyc;
    int n;
    do_reset();
    lat = 1;
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb_pc.push_back(RESET_PC + 64'(4 * i));
    first_cyc = -1;
    n = 0;
    for (int i = 0; i < 40 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        if (first_cyc < 0) first_cyc = cyc - 1;
        tests++;
        if (x_pc !== e || x_instr !== e[31:0] || (cyc - 1) !== first_cyc + n) begin
          fails++;
          $display("FAIL line_xfer pc=%h instr=%h cycle=%0d want pc=%h cycle=%0d", x_pc, x_instr, cyc - 1, e, first_cyc + n);
        end
        n++;
      end
    end
    tests++; if (first_cyc !== 2) begin fails++; $display("FAIL line_latency first transfer cycle %0d want 2", first_cyc); end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL line_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  task automatic test_decode_stall();
    do_reset();
    lat = 1;
    id_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_valid) begin
        tests++;
        if (s_pc !== RESET_PC || s_instr !== RESET_PC[31:0]) begin
          fails++; $display("FAIL stall_head cycle %0d pc=%h instr=%h want pc=%h", cyc - 1, s_pc, s_instr, RESET_PC);
        end
      end
    end
    tests++; if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      fails++; $display("FAIL stall_full req=%b valid=%b want req=0 valid=1", s_req, s_valid);
    end
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) sb_pc.push_back(RESET_PC + 64'(4 * i));
    for (int i = 0; i < 60 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        tests++;
        if (x_pc !== e || x_instr !== e[31:0]) begin
          fails++; $display("FAIL stall_xfer pc=%h instr=%h want pc=%h", x_pc, x_instr, e);
        end
      end
    end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL stall_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3;
    id_ready = 1'b1;
    cycle();
    cycle();
    redirect = 1'b1;
    redirect_pc = 64'h8000_1000;
    cycle();
    redirect = 1'b0;
    tests++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      fails++; $display("FAIL redir_cycle valid=%b req=%b want 0 0", s_valid, s_req);
    end
    for (int i = 0; i < 6; i++) sb_pc.push_back(64'h8000_1000 + 64'(4 * i));
    cycle();
    tests++; if (s_req !== 1'b1 || s_addr !== 64'h8000_1000) begin
      fails++; $display("FAIL redir_first_req req=%b addr=%h want 1 80001000", s_req, s_addr);
    end
    for (int i = 0; i < 60 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        tests++;
        if (x_pc !== e || x_instr !== e[31:0]) begin
          fails++; $display("FAIL redir_xfer pc=%h instr=%h want pc=%h", x_pc, x_instr, e);
        end
      end
    end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL redir_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  task automatic test_redirect_during_transfer();
    do_reset();
    lat = 1;
    id_ready = 1'b1;
    cycle();
    cycle();
    redirect = 1'b1;
    redirect_pc = 64'h8000_2000;
    cycle();
    redirect = 1'b0;
    tests++; if (s_valid !== 1'b0 || x_fire !== 1'b0) begin
      fails++; $display("FAIL squash_valid valid=%b fire=%b want 0 0", s_valid, x_fire);
    end
    for (int i = 0; i < 5; i++) sb_pc.push_back(64'h8000_2000 + 64'(4 * i));
    for (int i = 0; i < 40 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        tests++;
        if (x_pc !== e || x_instr !== e[31:0]) begin
          fails++; $display("FAIL squash_xfer pc=%h instr=%h want pc=%h", x_pc, x_instr, e);
        end
      end
    end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL squash_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  task automatic test_misalign();
    do_reset();
    lat = 1;
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h8000_0002;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests++;
      if (s_mis !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
        fails++; $display("FAIL misalign_hold misalign=%b req=%b valid=%b want 1 0 0", s_mis, s_req, s_valid);
      end
    end
    redirect = 1'b1;
    redirect_pc = 64'h8000_0010;
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) sb_pc.push_back(64'h8000_0010 + 64'(4 * i));
    cycle();
    tests++; if (s_mis !== 1'b0 || s_req !== 1'b1 || s_addr !== 64'h8000_0010) begin
      fails++; $display("FAIL misalign_clear misalign=%b req=%b addr=%h want 0 1 80000010", s_mis, s_req, s_addr);
    end
    for (int i = 0; i < 40 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        tests++;
        if (x_pc !== e || x_instr !== e[31:0]) begin
          fails++; $display("FAIL misalign_xfer pc=%h instr=%h want pc=%h", x_pc, x_instr, e);
        end
      end
    end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL misalign_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 1;
    id_ready = 1'b0;
    repeat (3) cycle();
    #1;
    tests++; if (valid !== 1'b1 || pc !== RESET_PC) begin
      fails++; $display("FAIL mid_prefill valid=%b pc=%h want 1 %h", valid, pc, RESET_PC);
    end
    rst = 1'b1;
    #1;
    tests++; if (valid !== 1'b0 || instr !== 32'h0 || pc !== 64'h0) begin
      fails++; $display("FAIL mid_async valid=%b instr=%h pc=%h want 0 0 0", valid, instr, pc);
    end
    mq_addr.delete();
    mq_due.delete();
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb_pc.push_back(RESET_PC + 64'(4 * i));
    cycle();
    tests++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      fails++; $display("FAIL mid_restart req=%b addr=%h want 1 %h", s_req, s_addr, RESET_PC);
    end
    for (int i = 0; i < 40 && sb_pc.size() != 0; i++) begin
      cycle();
      if (x_fire) begin
        logic [63:0] e;
        e = sb_pc.pop_front();
        tests++;
        if (x_pc !== e || x_instr !== e[31:0]) begin
          fails++; $display("FAIL mid_xfer pc=%h instr=%h want pc=%h", x_pc, x_instr, e);
        end
      end
    end
    tests++; if (sb_pc.size() != 0) begin fails++; $display("FAIL mid_drain %0d pcs missing want 0", sb_pc.size()); end
  endtask

  initial begin
    test_reset();
    test_straight_line();
    test_decode_stall();
    test_redirect_inflight();
    test_redirect_during_transfer();
    test_misalign();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
